// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Register map offsets, CTRL bit positions and the per-channel
//                control type shared by the programmable timer block.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package timer_pkg;

    // Word addresses of the global registers
    localparam int unsigned REG_PRESC  = 0;
    localparam int unsigned REG_STATUS = 1;

    // Channel c occupies CH_BASE + CH_STRIDE*c .. +CH_STRIDE-1
    localparam int unsigned CH_BASE    = 4;
    localparam int unsigned CH_STRIDE  = 4;

    // Offsets inside one channel window
    localparam int unsigned CH_CTRL    = 0;
    localparam int unsigned CH_CMP     = 1;
    localparam int unsigned CH_CNT     = 2;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    // Packed so that a 3-bit readback reads {irq_en, periodic, en}
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ch_ctrl_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_channel
//  Description : One timer channel: control/compare/count registers, compare
//                match, periodic or one-shot behaviour and the pending flag.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             cmp_we,
    input  logic             cnt_we,
    input  logic             clr,
    input  ch_ctrl_t         ctrl_wdata,
    input  logic [CNT_W-1:0] wdata,
    output ch_ctrl_t         ctrl,
    output logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    logic match;
    logic hit;

    assign match = (cnt == cmp);
    assign hit   = tick & ctrl.en & match;

    // Control register; a one-shot clears its own enable on the event unless software writes CTRL that cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= ctrl_wdata;
        end else if (hit && !ctrl.periodic) begin
            ctrl.en <= 1'b0;
        end
    end

    // Compare register, software-owned only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp <= '0;
        end else if (cmp_we) begin
            cmp <= wdata;
        end
    end

    // Counter: software write beats the tick; one-shot holds on match, overflow wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_we) begin
            cnt <= wdata;
        end else if (tick && ctrl.en) begin
            if (match) begin
                if (ctrl.periodic) begin
                    cnt <= '0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pending flag: a hardware event outranks a simultaneous W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (hit) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule : timer_channel
`default_nettype wire

// File: rtl/prog_timer_intrpt.sv
`default_nettype none
// ============================================================================
//  Module      : prog_timer_intrpt
//  Description : Multi-channel programmable timer-interrupt generator with a
//                shared prescaler, register-bus decode, W1C STATUS and a
//                registered readback path.
//                Build option TIMER_PRESCALER_EN: when defined, the PRESC
//                register and prescale counter exist; otherwise every cycle
//                is a tick and PRESC reads as 0.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module prog_timer_intrpt
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [NUM_CH-1:0] pending,
    output logic              intrpt
);

    localparam int STRIDE_SH = $clog2(CH_STRIDE);

    localparam logic [ADDR_W-1:0]    A_PRESC   = ADDR_W'(REG_PRESC);
    localparam logic [ADDR_W-1:0]    A_STATUS  = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0]    A_CH_BASE = ADDR_W'(CH_BASE);
    localparam logic [STRIDE_SH-1:0] OFF_CTRL  = STRIDE_SH'(CH_CTRL);
    localparam logic [STRIDE_SH-1:0] OFF_CMP   = STRIDE_SH'(CH_CMP);
    localparam logic [STRIDE_SH-1:0] OFF_CNT   = STRIDE_SH'(CH_CNT);

    logic                 tick;
    logic [31:0]          presc_rd;
    logic                 in_ch;
    logic [ADDR_W-1:0]    rel;
    logic [ADDR_W-1:0]    ch_idx;
    logic [STRIDE_SH-1:0] off;
    logic                 status_we;
    logic [NUM_CH-1:0]    irq_vec;
    logic [31:0]          rd_val;
    ch_ctrl_t             ctrl_wdata;
    ch_ctrl_t             ctrl_arr [NUM_CH];
    logic [CNT_W-1:0]     cmp_arr  [NUM_CH];
    logic [CNT_W-1:0]     cnt_arr  [NUM_CH];
    logic                 unused_wdata;

    // Unused upper write-data bits are intentionally ignored
    assign unused_wdata = ^wdata;

    // Address decode into global registers and channel windows
    assign in_ch     = (addr >= A_CH_BASE);
    assign rel       = addr - A_CH_BASE;
    assign ch_idx    = rel >> STRIDE_SH;
    assign off       = rel[STRIDE_SH-1:0];
    assign status_we = wr_en && (addr == A_STATUS);

    assign ctrl_wdata = '{irq_en:   wdata[CTRL_IRQ_EN],
                          periodic: wdata[CTRL_PERIODIC],
                          en:       wdata[CTRL_EN]};

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic               presc_we;

    assign presc_we = wr_en && (addr == A_PRESC);
    assign tick     = (presc_cnt == presc);
    assign presc_rd = 32'(presc);

    // Prescale divider; reprogramming restarts the count so the new period starts cleanly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (presc_we) begin
            presc     <= wdata[PRESC_W-1:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = '0;
`endif

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic sel;
            assign sel = in_ch && (ch_idx == ADDR_W'(c));

            timer_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .ctrl_we    (wr_en && sel && (off == OFF_CTRL)),
                .cmp_we     (wr_en && sel && (off == OFF_CMP)),
                .cnt_we     (wr_en && sel && (off == OFF_CNT)),
                .clr        (status_we && wdata[c]),
                .ctrl_wdata (ctrl_wdata),
                .wdata      (wdata[CNT_W-1:0]),
                .ctrl       (ctrl_arr[c]),
                .cmp        (cmp_arr[c]),
                .cnt        (cnt_arr[c]),
                .pending    (pending[c])
            );

            assign irq_vec[c] = ctrl_arr[c].irq_en;
        end
    endgenerate

    assign intrpt = |(pending & irq_vec);

    // Readback mux over the current register state; unmapped addresses read zero
    always_comb begin
        rd_val = '0;
        if (addr == A_PRESC) begin
            rd_val = presc_rd;
        end else if (addr == A_STATUS) begin
            rd_val = 32'(pending);
        end else if (in_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == ADDR_W'(c)) begin
                    if (off == OFF_CTRL) begin
                        rd_val = 32'(ctrl_arr[c]);
                    end else if (off == OFF_CMP) begin
                        rd_val = 32'(cmp_arr[c]);
                    end else if (off == OFF_CNT) begin
                        rd_val = 32'(cnt_arr[c]);
                    end
                end
            end
        end
    end

    // Registered read port; data captured before any same-cycle write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_val;
            end
        end
    end

endmodule : prog_timer_intrpt
`default_nettype wire

// File: tb/tb_prog_timer_intrpt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_timer_intrpt
//  Description : Self-checking bench for prog_timer_intrpt with a behavioural
//                reference model, directed scenarios and random register
//                traffic. Honours TIMER_PRESCALER_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_timer_intrpt;

`ifdef TIMER_PRESCALER_EN
    localparam bit HAS_PRESC = 1'b1;
`else
    localparam bit HAS_PRESC = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  pending;
    logic        intrpt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_presc, m_pcnt;
    bit          m_en[4], m_per[4], m_irq[4], m_pend[4];
    int unsigned m_cmp[4], m_cnt[4];
    logic [31:0] m_rdata;
    bit          m_rvalid;

    prog_timer_intrpt dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .pending (pending),
        .intrpt  (intrpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_presc = 0; m_pcnt = 0; m_rdata = '0; m_rvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_irq[c] = 0; m_pend[c] = 0;
            m_cmp[c] = 0; m_cnt[c] = 0;
        end
    endfunction

    function automatic bit m_tick();
        return !HAS_PRESC || (m_pcnt == m_presc);
    endfunction

    function automatic bit m_hit(int c);
        return m_tick() && m_en[c] && (m_cnt[c] == m_cmp[c]);
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v = '0;
        for (int c = 0; c < 4; c++) v[c] = m_pend[c];
        return v;
    endfunction

    function automatic logic [31:0] m_irq_out();
        bit any = 0;
        for (int c = 0; c < 4; c++) any = any | (m_pend[c] & m_irq[c]);
        return 32'(any);
    endfunction

    function automatic logic [31:0] m_read(int a);
        int c, o;
        if (a == 0) return HAS_PRESC ? 32'(m_presc) : 32'd0;
        if (a == 1) return m_pend_vec();
        if (a < 4) return 32'd0;
        c = (a - 4) / 4;
        o = (a - 4) % 4;
        if (c >= 4) return 32'd0;
        case (o)
            0:       return {29'd0, m_irq[c], m_per[c], m_en[c]};
            1:       return 32'(m_cmp[c]);
            2:       return 32'(m_cnt[c]);
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare outputs
    task automatic step(input bit w, input bit r, input int a, input logic [31:0] d);
        bit          t;
        bit          h[4];
        logic [31:0] rv;
        int          c, o;
        wr_en = w; rd_en = r; addr = 6'(a); wdata = d;
        t  = m_tick();
        for (int i = 0; i < 4; i++) h[i] = m_hit(i);
        rv = m_read(a);
        @(posedge clk);
        m_rvalid = r;
        if (r) m_rdata = rv;
        if (w && a == 1)
            for (int i = 0; i < 4; i++) if (d[i]) m_pend[i] = 0;
        for (int i = 0; i < 4; i++) begin
            if (t && m_en[i]) begin
                if (h[i]) begin
                    m_pend[i] = 1;
                    if (m_per[i]) m_cnt[i] = 0;
                    else          m_en[i]  = 0;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % 65536;
                end
            end
        end
        if (w && a >= 4) begin
            c = (a - 4) / 4;
            o = (a - 4) % 4;
            if (c < 4) begin
                case (o)
                    0: begin m_en[c] = d[0]; m_per[c] = d[1]; m_irq[c] = d[2]; end
                    1: m_cmp[c] = d[15:0];
                    2: m_cnt[c] = d[15:0];
                    default: ;
                endcase
            end
        end
        if (HAS_PRESC) begin
            if (w && a == 0) begin m_presc = d[7:0]; m_pcnt = 0; end
            else             m_pcnt = t ? 0 : m_pcnt + 1;
        end
        #1;
        chk("pending", 32'(pending), m_pend_vec());
        chk("intrpt", 32'(intrpt), m_irq_out());
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        if (m_rvalid) chk("rdata", rdata, m_rdata);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0);
    endtask

    // Bounded wait for a pending bit; n keeps counting edges from its start value
    task automatic wait_pend(input int c, input int maxn, inout int n);
        while (pending[c] !== 1'b1 && n < maxn) begin
            idle();
            n++;
        end
    endtask

    initial begin
        int n, k, a, o;
        logic [31:0] d;
        int presc_eff;

        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_rdata", rdata, 0);
        chk("reset_rvalid", 32'(rvalid), 0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_intrpt", 32'(intrpt), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: periodic ch0, CMP=29, PRESC=0 -> event every 30 cycles
        step(1, 0, 0, 0);
        step(1, 0, 5, 29);
        step(1, 0, 4, 7);
        n = 0; wait_pend(0, 200, n);
        chk("t1_first_period", n, 30);
        chk("t1_intrpt", 32'(intrpt), 1);
        step(0, 1, 6, 0);
        chk("t1_cnt_back_to_0", rdata, 0);
        step(1, 0, 1, 1);
        n = 2; wait_pend(0, 200, n);
        chk("t1_period", n, 30);
        step(1, 0, 4, 0);
        step(1, 0, 1, 15);

        // 2: one-shot ch1, CMP=4, PRESC=3
        presc_eff = HAS_PRESC ? 3 : 0;
        step(1, 0, 0, 3);
        step(1, 0, 9, 4);
        step(1, 0, 10, 0);
        k = 0;
        while (!m_tick() && k < 10) begin idle(); k++; end
        step(1, 0, 8, 5);
        n = 0; wait_pend(1, 200, n);
        chk("t2_oneshot_delay", n, 5 * (presc_eff + 1));
        step(0, 1, 8, 0);
        chk("t2_en_cleared", rdata, 4);
        step(0, 1, 10, 0);
        chk("t2_cnt_holds", rdata, 4);
        step(1, 0, 1, 2);
        repeat (40) idle();
        chk("t2_single_event", 32'(pending[1]), 0);
        step(1, 0, 0, 0);

        // 3: W1C coinciding with a match -> set wins
        step(1, 0, 5, 5);
        step(1, 0, 6, 0);
        step(1, 0, 4, 3);
        n = 0; wait_pend(0, 50, n);
        chk("t3_first", n, 6);
        k = 0;
        while (!m_hit(0) && k < 50) begin idle(); k++; end
        step(1, 0, 1, 1);
        chk("t3_set_wins", 32'(pending[0]), 1);
        step(1, 0, 4, 0);
        step(1, 0, 1, 15);
        chk("t3_cleared", 32'(pending), 0);
        chk("t3_intrpt_low", 32'(intrpt), 0);

        // 4: compare at full scale, then wrap without an event
        step(1, 0, 13, 32'hFFFF);
        step(1, 0, 14, 32'hFFFE);
        step(1, 0, 12, 3);
        n = 0; wait_pend(2, 20, n);
        chk("t4_max_match", n, 2);
        step(0, 1, 14, 0);
        chk("t4_cnt_reset", rdata, 0);
        step(1, 0, 12, 0);
        step(1, 0, 1, 4);
        step(1, 0, 13, 32'h10);
        step(1, 0, 14, 32'hFFFD);
        step(1, 0, 12, 3);
        repeat (10) idle();
        chk("t4_wrap_no_event", 32'(pending[2]), 0);
        step(0, 1, 14, 0);
        chk("t4_wrapped_cnt", rdata, 7);
        step(1, 0, 14, 32'h20);
        repeat (40) idle();
        chk("t4_above_cmp_no_event", 32'(pending[2]), 0);
        step(1, 1, 13, 32'h55);
        chk("t4_rw_same_addr_old", rdata, 32'h10);
        step(0, 1, 13, 0);
        chk("t4_rw_new_value", rdata, 32'h55);
        step(1, 0, 12, 0);
        step(1, 0, 1, 15);

        // 5: asynchronous reset mid-count
        step(1, 0, 5, 3);
        step(1, 0, 4, 7);
        repeat (8) idle();
        step(0, 1, 5, 0);
        chk("t5_pre_rdata", rdata, 3);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_rdata", rdata, 0);
        chk("t5_async_rvalid", 32'(rvalid), 0);
        chk("t5_async_pending", 32'(pending), 0);
        chk("t5_async_intrpt", 32'(intrpt), 0);
        m_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        idle();
        step(1, 0, 5, 3);
        step(1, 0, 4, 7);
        n = 0; wait_pend(0, 50, n);
        chk("t5_restart", n, 4);
        step(1, 0, 4, 0);
        step(1, 0, 1, 15);

        // 6: match with irq_en=0, then enable the interrupt
        step(1, 0, 17, 2);
        step(1, 0, 16, 1);
        n = 0; wait_pend(3, 50, n);
        chk("t6_delay", n, 3);
        chk("t6_masked", 32'(intrpt), 0);
        step(1, 0, 16, 4);
        chk("t6_irq_enable", 32'(intrpt), 1);
        step(1, 0, 1, 15);
        step(1, 0, 16, 0);

        // Random register traffic against the model
        for (int i = 0; i < 2000; i++) begin
            a = $urandom_range(0, 23);
            d = $urandom;
            if (a == 0) d = d & 32'h3;
            if (a >= 4) begin
                o = (a - 4) % 4;
                if (o == 1) d = d & 32'h1F;
                if (o == 2) d = ($urandom_range(0, 7) == 0) ? (32'hFFF0 | (d & 32'hF)) : (d & 32'h1F);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_prog_timer_intrpt
`default_nettype wire
